// File: rtl/mod100_display_scan.sv
// Two-digit multiplexed 7-segment driver for the mod-100 counter's BCD pair.
// Optional leading-zero blanking of the tens digit: define MOD100_DISPLAY_SCAN_LZB_EN.
module mod100_display_scan #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       load,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic {
        UNITS = 1'b0,
        TENS  = 1'b1
    } slot_t;

    logic [PW-1:0] pc_r;
    slot_t         slot_r;
    logic [3:0]    sh1_r;
    logic [3:0]    sh0_r;
    logic [3:0]    digit_s;
    logic          dark_s;
    logic [1:0]    an_s;
    logic [6:0]    seg_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Next-cycle drive: dark during blank, dead time, or a blanked leading zero.
    always_comb begin
        digit_s = 4'd0;
        dark_s  = 1'b0;
        an_s    = 2'b00;
        seg_s   = 7'h00;
        if (slot_r == TENS) begin
            digit_s = sh1_r;
            an_s    = 2'b10;
        end else begin
            digit_s = sh0_r;
            an_s    = 2'b01;
        end
        if (blank) begin
            dark_s = 1'b1;
        end else if (pc_r == '0) begin
            dark_s = 1'b1;
`ifdef MOD100_DISPLAY_SCAN_LZB_EN
        end else if ((slot_r == TENS) && (sh1_r == 4'd0)) begin
            dark_s = 1'b1;
`endif
        end else begin
            dark_s = 1'b0;
        end
        seg_s = seg_decode(digit_s);
    end

    // Prescaler, slot toggle, shadow capture, sticky error and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r   <= '0;
            slot_r <= UNITS;
            sh1_r  <= 4'd0;
            sh0_r  <= 4'd0;
            err    <= 1'b0;
            seg    <= 7'h00;
            an     <= 2'b00;
        end else begin
            if (pc_r == PC_LAST) begin
                pc_r <= '0;
                case (slot_r)
                    UNITS:   slot_r <= TENS;
                    TENS:    slot_r <= UNITS;
                    default: slot_r <= UNITS;
                endcase
            end else begin
                pc_r <= pc_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (load) begin
                sh1_r <= d1;
                sh0_r <= d0;
                if ((d1 > 4'd9) || (d0 > 4'd9)) begin
                    err <= 1'b1;
                end
            end
            if (dark_s) begin
                seg <= 7'h00;
                an  <= 2'b00;
            end else begin
                seg <= seg_s;
                an  <= an_s;
            end
        end
    end

endmodule

// File: tb/tb_mod100_display_scan.sv
// Randomized bench for mod100_display_scan with an arithmetic time-based reference model.
module tb_mod100_display_scan;

    localparam int SD = 4;
`ifdef MOD100_DISPLAY_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d1 = 4'd0;
    logic [3:0] d0 = 4'd0;
    logic       load = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int checks = 0;
    int errors = 0;

    mod100_display_scan #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .d1(d1), .d0(d0), .load(load),
        .blank(blank), .seg(seg), .an(an), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: position in the scan follows from edges since reset.
    int         k;
    logic [3:0] m1, m0;
    logic       merr;
    logic [6:0] eseg;
    logic [1:0] ean;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] tab [0:9];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 4'd9) return 7'h40;
        return tab[d];
    endfunction

    always @(posedge clk or posedge rst) begin
        int  pc;
        bit  tens, lit;
        if (rst) begin
            k <= 0; m1 <= 4'd0; m0 <= 4'd0; merr <= 1'b0;
            eseg <= 7'h00; ean <= 2'b00;
        end else begin
            pc   = k % SD;
            tens = ((k / SD) % 2) == 1;
            lit  = !blank && (pc != 0) && !(LZB && tens && (m1 == 4'd0));
            ean  <= lit ? (tens ? 2'b10 : 2'b01) : 2'b00;
            eseg <= lit ? glyph(tens ? m1 : m0) : 7'h00;
            if (load) begin
                m1 <= d1; m0 <= d0;
                if (d1 > 4'd9 || d0 > 4'd9) merr <= 1'b1;
            end
            k <= k + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("seg", {25'd0, seg}, {25'd0, eseg});
            check("an", {30'd0, an}, {30'd0, ean});
            check("err", {31'd0, err}, {31'd0, merr});
            load = 1'b0;
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] u);
        d1 = t; d0 = u; load = 1'b1;
        step(1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, seg}, 32'h0);
        check("rst_an", {30'd0, an}, 32'h0);
        rst = 1'b0;
        step(1);
        check("first_dead_an", {30'd0, an}, 32'h0);
        step(1);
        check("first_lit_seg", {25'd0, seg}, 32'h3F);
        check("first_lit_an", {30'd0, an}, 32'h1);
        step(6);

        do_load(4'd4, 4'd7);
        step(16);
        do_load(4'd3, 4'd12);
        step(10);
        check("err_set", {31'd0, err}, 32'h1);
        do_load(4'd1, 4'd2);
        step(10);
        check("err_sticky", {31'd0, err}, 32'h1);

        // blank across a tens slot
        for (int i = 0; i < 2 * SD && (k % (2 * SD)) != SD + 1; i++) step(1);
        blank = 1'b1;
        step(10);
        blank = 1'b0;
        step(10);

        do_load(4'd0, 4'd5);
        step(16);

        // load on the edge where the slot toggles, then unloaded input churn
        for (int i = 0; i < 2 * SD && (k % (2 * SD)) != SD - 1; i++) step(1);
        check("align", k % (2 * SD), SD - 1);
        do_load(4'd9, 4'd9);
        d1 = 4'd2; d0 = 4'd3;
        step(2);
        check("toggle_seg", {25'd0, seg}, 32'h6F);
        check("toggle_an", {30'd0, an}, 32'h2);
        step(12);

        for (int i = 0; i < 400; i++) begin
            d1 = 4'($urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) d1 = 4'd0;
            load  = ($urandom_range(0, 5) == 0);
            blank = ($urandom_range(0, 11) == 0);
            step(1);
        end
        blank = 1'b0;
        do_load(4'd8, 4'd15);
        step(5);

        // asynchronous reset mid-slot, away from any clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_seg", {25'd0, seg}, 32'h0);
        check("async_an", {30'd0, an}, 32'h0);
        check("async_err", {31'd0, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(2);
        check("rerst_seg", {25'd0, seg}, 32'h3F);
        check("rerst_an", {30'd0, an}, 32'h1);
        step(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
